// File: rtl/imm_decode_stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_decode_stage_pkg: shared opcodes, format codes and buffer states.
// Revision: 1.0
// ---------------------------------------------------------------------------
package imm_decode_stage_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SYS  = 3'd6,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage
`default_nettype wire

// File: rtl/imm_decode_stage_comb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_decode_comb: combinational instruction -> {imm, fmt, illegal} decoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
module imm_decode_comb
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  // Field arrives right-aligned and zero-padded; width is its bit count.
  function automatic logic [XLEN-1:0] ext(input logic [31:0] field,
                                          input logic [5:0]  width,
                                          input logic        sx);
    logic [XLEN-1:0] mask;
    logic            msb;
    mask = {XLEN{1'b1}} << width;
    msb  = |(field & (32'd1 << (width - 6'd1)));
    if (sx && msb)
      ext = XLEN'(field) | mask;
    else
      ext = XLEN'(field) & ~mask;
  endfunction

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_OP: fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        imm = ext(32'(instr[31:20]), 6'd12, SIGN_EXT);
      end
      OPC_MISC_MEM: fmt = FMT_I;
      OPC_STORE: begin
        fmt = FMT_S;
        imm = ext(32'({instr[31:25], instr[11:7]}), 6'd12, SIGN_EXT);
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = ext(32'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}),
                  6'd13, SIGN_EXT);
      end
      // U and J immediates are signed regardless of the legacy mode.
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = ext({instr[31:12], 12'b0}, 6'd32, 1'b1);
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = ext(32'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}),
                  6'd21, 1'b1);
      end
      OPC_SYSTEM: begin
        fmt = FMT_SYS;
        imm = ext(32'(instr[31:20]), 6'd12, 1'b0);
      end
      default: begin
        fmt     = FMT_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_decode_stage: registered immediate decode with a two-entry skid buffer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;
  logic            w_dec_illegal;

  imm_decode_comb #(
    .XLEN     (XLEN),
    .SIGN_EXT (SIGN_EXT)
  ) u_decode (
    .instr   (in_instr),
    .imm     (w_dec_imm),
    .fmt     (w_dec_fmt),
    .illegal (w_dec_illegal)
  );

  buf_state_e      r_state;
  buf_state_e      w_state_next;
  logic [31:0]     r_main_instr, r_skid_instr;
  logic [XLEN-1:0] r_main_imm,   r_skid_imm;
  logic [2:0]      r_main_fmt,   r_skid_fmt;
  logic            r_main_ill,   r_skid_ill;

  logic w_in_xfer, w_out_xfer;
  logic w_load_main_in, w_load_main_skid, w_load_skid;

  // Both handshake outputs decode straight from the state register.
  assign in_ready    = (r_state != BUF_TWO);
  assign out_valid   = (r_state != BUF_EMPTY);
  assign out_instr   = r_main_instr;
  assign out_imm     = r_main_imm;
  assign out_fmt     = r_main_fmt;
  assign out_illegal = r_main_ill;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_next = BUF_EMPTY;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (w_in_xfer) begin
            w_load_main_in = 1'b1;
            w_state_next   = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_load_skid  = 1'b1;
            w_state_next = BUF_TWO;
          end else if (w_out_xfer) begin
            w_state_next = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (w_out_xfer) begin
            w_load_main_skid = 1'b1;
            w_state_next     = BUF_ONE;
          end
        end
        default: w_state_next = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= BUF_EMPTY;
      r_main_instr <= '0;
      r_main_imm   <= '0;
      r_main_fmt   <= '0;
      r_main_ill   <= 1'b0;
      r_skid_instr <= '0;
      r_skid_imm   <= '0;
      r_skid_fmt   <= '0;
      r_skid_ill   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load_main_in) begin
        r_main_instr <= in_instr;
        r_main_imm   <= w_dec_imm;
        r_main_fmt   <= w_dec_fmt;
        r_main_ill   <= w_dec_illegal;
      end else if (w_load_main_skid) begin
        r_main_instr <= r_skid_instr;
        r_main_imm   <= r_skid_imm;
        r_main_fmt   <= r_skid_fmt;
        r_main_ill   <= r_skid_ill;
      end
      if (w_load_skid) begin
        r_skid_instr <= in_instr;
        r_skid_imm   <= w_dec_imm;
        r_skid_fmt   <= w_dec_fmt;
        r_skid_ill   <= w_dec_illegal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imm_decode_stage: scoreboard bench over three parameterisations.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  // a: XLEN=32 sign-extend, b: XLEN=64 sign-extend, c: XLEN=32 legacy zero-extend
  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [31:0] out_instr_a, out_instr_b, out_instr_c;
  logic [31:0] out_imm_a, out_imm_c;
  logic [63:0] out_imm_b;
  logic [2:0]  out_fmt_a, out_fmt_b, out_fmt_c;
  logic        out_ill_a, out_ill_b, out_ill_c;

  imm_decode_stage #(.XLEN(32), .SIGN_EXT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_instr(out_instr_a), .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_ill_a));

  imm_decode_stage #(.XLEN(64), .SIGN_EXT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_instr(out_instr_b), .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_ill_b));

  imm_decode_stage #(.XLEN(32), .SIGN_EXT(1'b0)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_instr(in_instr), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_instr(out_instr_c), .out_imm(out_imm_c), .out_fmt(out_fmt_c), .out_illegal(out_ill_c));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm_s;
    logic [63:0] imm_z;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:                      return 3'd0;
      7'h13, 7'h03, 7'h67, 7'h0F: return 3'd1;
      7'h23:                      return 3'd2;
      7'h63:                      return 3'd3;
      7'h37, 7'h17:               return 3'd4;
      7'h6F:                      return 3'd5;
      7'h73:                      return 3'd6;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input bit sx);
    logic signed [63:0] v;
    logic [63:0] u, a20, a25, a31, s12, s31;
    v = $signed(ins);
    u = {32'b0, ins};
    s12 = v >>> 12;
    s31 = v >>> 31;
    if (sx) begin
      a20 = v >>> 20; a25 = v >>> 25; a31 = v >>> 31;
    end else begin
      a20 = u >> 20;  a25 = u >> 25;  a31 = u >> 31;
    end
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: return a20;
      7'h23: return (a25 << 5) | 64'(ins[11:7]);
      7'h63: return (a31 << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                    | (64'(ins[11:8]) << 1);
      7'h37, 7'h17: return s12 << 12;
      7'h6F: return (s31 << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
                    | (64'(ins[30:21]) << 1);
      7'h73: return u >> 20;
      default: return 64'd0;
    endcase
  endfunction

  // Scoreboard monitor: pushes on accepted input, pops on output transfer.
  logic        stall_prev = 1'b0;
  logic [31:0] sv_instr, sv_imm_a, sv_imm_c;
  logic [63:0] sv_imm_b;
  logic [2:0]  sv_fmt;
  logic        sv_ill;
  exp_t        mon_e;
  exp_t        push_e;

  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (out_valid_a !== 1'b1 || out_instr_a !== sv_instr || out_imm_a !== sv_imm_a ||
            out_fmt_a !== sv_fmt || out_ill_a !== sv_ill || out_imm_b !== sv_imm_b ||
            out_imm_c !== sv_imm_c) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b instr=%h imm=%h fmt=%0d, held instr=%h imm=%h fmt=%0d",
                   out_valid_a, out_instr_a, out_imm_a, out_fmt_a, sv_instr, sv_imm_a, sv_fmt);
        end
      end
      if (out_valid_a && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got instr=%h, expected no output", out_instr_a);
        end else begin
          mon_e = sb.pop_front();
          if (out_instr_a !== mon_e.instr || out_imm_a !== mon_e.imm_s[31:0] ||
              out_fmt_a !== mon_e.fmt || out_ill_a !== mon_e.ill) begin
            errors++;
            $display("FAIL sb_x32: got instr=%h imm=%h fmt=%0d ill=%0b, exp instr=%h imm=%h fmt=%0d ill=%0b",
                     out_instr_a, out_imm_a, out_fmt_a, out_ill_a,
                     mon_e.instr, mon_e.imm_s[31:0], mon_e.fmt, mon_e.ill);
          end
          checks++;
          if (out_valid_b !== 1'b1 || out_instr_b !== mon_e.instr || out_imm_b !== mon_e.imm_s ||
              out_fmt_b !== mon_e.fmt || out_ill_b !== mon_e.ill) begin
            errors++;
            $display("FAIL sb_x64: got v=%0b instr=%h imm=%h fmt=%0d, exp instr=%h imm=%h fmt=%0d",
                     out_valid_b, out_instr_b, out_imm_b, out_fmt_b, mon_e.instr, mon_e.imm_s, mon_e.fmt);
          end
          checks++;
          if (out_valid_c !== 1'b1 || out_instr_c !== mon_e.instr || out_imm_c !== mon_e.imm_z[31:0] ||
              out_fmt_c !== mon_e.fmt || out_ill_c !== mon_e.ill) begin
            errors++;
            $display("FAIL sb_zext: got v=%0b instr=%h imm=%h fmt=%0d, exp instr=%h imm=%h fmt=%0d",
                     out_valid_c, out_instr_c, out_imm_c, out_fmt_c, mon_e.instr, mon_e.imm_z[31:0], mon_e.fmt);
          end
        end
      end
      stall_prev = out_valid_a && !out_ready;
      sv_instr = out_instr_a; sv_imm_a = out_imm_a; sv_imm_b = out_imm_b;
      sv_imm_c = out_imm_c;   sv_fmt = out_fmt_a;   sv_ill = out_ill_a;
      if (in_valid && in_ready_a) begin
        push_e.instr = in_instr;
        push_e.imm_s = ref_imm(in_instr, 1'b1);
        push_e.imm_z = ref_imm(in_instr, 1'b0);
        push_e.fmt   = ref_fmt(in_instr);
        push_e.ill   = (ref_fmt(in_instr) == 3'd7);
        sb.push_back(push_e);
      end
    end
  end

  // Called and returns at posedge+1; holds the instruction until accepted.
  task automatic send(input logic [31:0] ins);
    logic acc;
    in_valid = 1'b1;
    in_instr = ins;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout: instr=%h not accepted, required within 100 cycles", ins);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid_a, in_ready_a, out_valid_b, in_ready_b, out_valid_c, in_ready_c} !== 6'b010101) begin
      errors++;
      $display("FAIL reset_handshake: got a v/r=%0b%0b b=%0b%0b c=%0b%0b, exp v=0 r=1",
               out_valid_a, in_ready_a, out_valid_b, in_ready_b, out_valid_c, in_ready_c);
    end
    checks++;
    if (out_imm_a !== 32'd0 || out_instr_a !== 32'd0 || out_fmt_a !== 3'd0 || out_ill_a !== 1'b0 ||
        out_imm_b !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: got imm=%h instr=%h fmt=%0d ill=%0b imm64=%h, exp all zero",
               out_imm_a, out_instr_a, out_fmt_a, out_ill_a, out_imm_b);
    end
    @(posedge clk);
    #1;
  endtask

  localparam int NDIR = 12;
  logic [31:0] d_ins   [NDIR] = '{32'hFFF00093, 32'hFE000EE3, 32'hFF9FF06F, 32'h800000B7,
                                  32'h0000007F, 32'h002081B3, 32'hFE112E23, 32'hC00020F3,
                                  32'h0FF0000F, 32'h12345017, 32'h7FF02083, 32'hFF008067};
  logic [31:0] d_imm32 [NDIR] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000,
                                  32'h0, 32'h0, 32'hFFFFFFFC, 32'h00000C00,
                                  32'h0, 32'h12345000, 32'h000007FF, 32'hFFFFFFF0};
  logic [31:0] d_immzx [NDIR] = '{32'h00000FFF, 32'h00001FFC, 32'hFFFFFFF8, 32'h80000000,
                                  32'h0, 32'h0, 32'h00000FFC, 32'h00000C00,
                                  32'h0, 32'h12345000, 32'h000007FF, 32'h00000FF0};
  logic [63:0] d_imm64 [NDIR] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                  64'hFFFFFFFF80000000, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC,
                                  64'h0000000000000C00, 64'h0, 64'h0000000012345000,
                                  64'h00000000000007FF, 64'hFFFFFFFFFFFFFFF0};
  logic [2:0]  d_fmt   [NDIR] = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd7, 3'd0, 3'd2, 3'd6, 3'd1, 3'd4, 3'd1, 3'd1};

  task automatic test_directed();
    out_ready = 1'b1;
    for (int i = 0; i < NDIR; i++) begin
      send(d_ins[i]);
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b1 || out_instr_a !== d_ins[i] || out_imm_a !== d_imm32[i] ||
          out_fmt_a !== d_fmt[i] || out_ill_a !== (d_fmt[i] == 3'd7)) begin
        errors++;
        $display("FAIL dir_x32[%0d]: got v=%0b imm=%h fmt=%0d ill=%0b, exp imm=%h fmt=%0d",
                 i, out_valid_a, out_imm_a, out_fmt_a, out_ill_a, d_imm32[i], d_fmt[i]);
      end
      checks++;
      if (out_imm_b !== d_imm64[i]) begin
        errors++;
        $display("FAIL dir_x64[%0d]: got imm=%h exp %h", i, out_imm_b, d_imm64[i]);
      end
      checks++;
      if (out_imm_c !== d_immzx[i]) begin
        errors++;
        $display("FAIL dir_zext[%0d]: got imm=%h exp %h", i, out_imm_c, d_immzx[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h00100093;
    @(posedge clk); #1;
    in_instr = 32'h00200113;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b1 || in_ready_a !== 1'b1 || out_instr_a !== 32'h00100093) begin
      errors++;
      $display("FAIL bp_first: got v=%0b r=%0b instr=%h, exp v=1 r=1 instr=00100093",
               out_valid_a, in_ready_a, out_instr_a);
    end
    @(posedge clk); #1;
    in_instr = 32'h00300193;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0 || out_valid_a !== 1'b1 ||
          out_instr_a !== 32'h00100093) begin
        errors++;
        $display("FAIL bp_full[%0d]: got r=%0b v=%0b instr=%h, exp r=0 v=1 instr=00100093",
                 k, in_ready_a, out_valid_a, out_instr_a);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_release_ready: got %0b exp 0", in_ready_a);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready_a !== 1'b1 || out_instr_a !== 32'h00200113) begin
      errors++;
      $display("FAIL bp_drain: got r=%0b instr=%h, exp r=1 instr=00200113", in_ready_a, out_instr_a);
    end
    @(posedge clk); #1;
    in_instr = 32'h00400213;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 0; t < 10 && (sb.size() != 0 || out_valid_a); t++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0 || out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_lost: got %0d pending v=%0b, exp 0 pending", sb.size(), out_valid_a);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h00500293);
    send(32'h00600313);
    in_valid = 1'b1; in_instr = 32'h00700393; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_valid_c !== 1'b0 || in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL flush_two: got v=%0b r=%0b, exp v=0 r=1", out_valid_a, in_ready_a);
    end
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid_a !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak: got v=%0b instr=%h, exp no output", out_valid_a, out_instr_a);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h00800413);
    in_valid = 1'b1; in_instr = 32'h00900493; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL flush_one_drop: got v=%0b r=%0b instr=%h, exp v=0 r=1", out_valid_a, in_ready_a, out_instr_a);
    end
    @(posedge clk); #1;
    send(32'h00A00513);
    send(32'h00B00593);
    in_valid = 1'b1; in_instr = 32'h00C00613; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got v=%0b r=%0b, exp v=0 r=1", out_valid_a, in_ready_a);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00D00693);
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b1 || out_instr_a !== 32'h00D00693) begin
      errors++;
      $display("FAIL flush_recover: got v=%0b instr=%h, exp v=1 instr=00D00693", out_valid_a, out_instr_a);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL flush_pending: got %0d pending, exp 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  logic [6:0] opc_list [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h23,
                                7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h00};

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        logic [31:0] ins;
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin
            @(posedge clk); #1;
          end
          ins = $urandom;
          ins[6:0] = opc_list[$urandom_range(0, 11)];
          if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom_range(0, 127));
          send(ins);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    for (int t = 0; t < 20 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: got %0d pending v=%0b, exp 0 pending", sb.size(), out_valid_a);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, handshaked immediate-decode stage for the V-FRONT pipeline, parametrised in data width. It accepts one instruction per cycle from fetch, classifies its encoding format, and builds the XLEN-wide immediate with RISC-V-compliant sign extension. A legacy mode reproduces the earlier zero-extending behaviour. A two-entry skid buffer gives full throughput under backpressure, and a flush input discards in-flight entries on redirects.

## Interface
- XLEN, 32, immediate/datapath width; legal values 32 and 64.
- SIGN_EXT, 1, 1 = sign-extend I/S/B/JALR/LOAD immediates; 0 = legacy zero-extend of those formats.
- clk  in  1  clock; everything on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  instruction passed through.
- out_imm  out  XLEN  immediate.
- out_fmt  out  3  format code.
- out_illegal  out  1  opcode not recognised.

## Operation
- Opcode = instr[6:0]; constants come from the shared opcode list.
- R: fmt 0, imm 0.
- I / LOAD / JALR: fmt 1, imm = ext(instr[31:20]).
- S: fmt 2, imm = ext({instr[31:25], instr[11:7]}).
- B: fmt 3, imm = ext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- LUI / AUIPC: fmt 4, imm = {instr[31:12], 12'b0}. For XLEN=64 this value is always sign-extended from bit 31.
- JAL: fmt 5, imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}, always sign-extended.
- SYSTEM: fmt 6, imm = zero-extended CSR address instr[31:20].
- FENCE: fmt 1, imm 0.
- Any other opcode: fmt 7, imm 0, out_illegal = 1.
- ext() means sign extension of the field MSB when SIGN_EXT=1, and zero extension when SIGN_EXT=0.
- Buffering: main register plus one skid register. Entries drain in FIFO order.
  - in_ready = !skid_valid, registered.
  - Input transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
- Buffer states:
  - EMPTY → ONE on an accepted input.
  - ONE → TWO on an accepted input with no output transfer.
  - ONE → EMPTY on an output transfer with no input.
  - ONE stays in ONE on simultaneous input and output.
  - TWO → ONE on an output transfer (no input possible, since in_ready = 0).
- flush has priority over everything. Next state is EMPTY; any input offered in the same cycle is dropped.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 instruction per cycle while out_ready is high.
- With out_ready low, at most 2 instructions are held. in_ready falls in the cycle after the second accept.
- in_ready returns to 1 in the cycle after a drain from TWO.
- out_valid, out_imm, out_instr, out_fmt and out_illegal stay stable while out_valid && !out_ready.
- Reset values: out_valid 0, in_ready 1, out_imm 0, out_instr 0, out_fmt 0, out_illegal 0, skid_valid 0.
- Reset or flush in the middle of a stream: the next cycle shows out_valid = 0 and in_ready = 1.
- The decode logic is combinational on the input side only. No combinational path exists from out_ready to in_ready.

## Structure
- The shared header holds:
  - opcode constants, extended with any opcodes not yet defined there;
  - the 3-bit format codes FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS, FMT_NONE.
- Sub-module imm_decode_comb(XLEN, SIGN_EXT): purely combinational, instr → {imm, fmt, illegal}.
- The top level contains the skid buffer and control state only.

## Test plan
- XLEN=32, SIGN_EXT=1, addi x1,x0,-1 (0xFFF00093) → one cycle later out_imm=0xFFFFFFFF, fmt=1, illegal=0. With SIGN_EXT=0 → out_imm=0x00000FFF.
- beq x0,x0,-4 (0xFE000EE3) → out_imm=0xFFFFFFFC, fmt=3. jal x0,-8 (0xFF9FF06F) → out_imm=0xFFFFFFF8, fmt=5.
- XLEN=64, lui x1,0x80000 (0x800000B7) → out_imm=0xFFFFFFFF80000000, fmt=4. Opcode 0x7F → fmt=7, illegal=1, imm=0.
- Backpressure: stream 4 instructions with out_ready held low → 2 accepted, in_ready=0 from the cycle after the second accept. Release out_ready → outputs appear in order, 1 per cycle, nothing lost or duplicated.
- Flush with the buffer in TWO and in_valid high → next cycle out_valid=0 and in_ready=1. The flushed instructions and the same-cycle input never appear at the output.
- Randomised valid/ready against a reference decoder (2000 instructions) → output sequence matches, and outputs stay stable whenever the output is stalled.
